mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Round-robin arbiter that shares the single-port synchronous data memory between up to four multiplier cores of the processor.
- Honours the `core_sel` active-core count and masks cores that have raised `end_op`.
- Sequences each access through a fixed issue/response pipeline.
- Sits between the core array and the data RAM, and reports when every active core has finished.

Parameters:
- ADDR_W, 12, data-memory address width.
- DATA_W, 8, data-memory word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- core_sel  in  3  number of active cores: 1..4; 0 → 1; 5..7 → 4.
- end_op  in  4  per-core finished flags; bit i masks core i.
- req  in  4  per-core access request; held high until the matching ack.
- we  in  4  per-core write enable, qualified by req.
- addr_bus  in  4*ADDR_W  core i address at [i*ADDR_W +: ADDR_W].
- wdata_bus  in  4*DATA_W  core i write data at [i*DATA_W +: DATA_W].
- grant  out  4  one-hot, the core currently owning memory.
- ack  out  4  one-hot, one-cycle completion pulse.
- rd_data  out  DATA_W  read data, valid only while an ack bit is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  RAM output; 1-cycle read latency (registered RAM).
- busy  out  1  FSM not in IDLE.
- all_done  out  1  every active core has end_op set and FSM is IDLE.

Behaviour:
- Eligible set = req & active_mask & ~end_op; active_mask = low n bits for clamped core_sel n.
- Round-robin: search from ptr+1 upward modulo 4. First eligible core wins. ptr := winner when ack fires.
- FSM states IDLE, ISSUE, RESP. All outputs except rd_data are registered.
- IDLE: if eligible ≠ 0 → ISSUE. Latch winner index plus its addr/we/wdata; grant=onehot(winner).
- ISSUE: mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values, for exactly one cycle → RESP.
- RESP: ack[winner]=1 and rd_data=mem_rdata, for one cycle.
  - Re-arbitrate excluding the current winner, whose req is still high this cycle.
  - If a core wins → ISSUE with the new winner, giving back-to-back service at one access per 2 cycles.
  - Otherwise → IDLE with grant=0.
- Latency: req sampled in IDLE at cycle T → mem_en at T+1 → ack at T+2.
- Writes: ack pulses identically; rd_data is don't-care.
- end_op rising or core_sel changing mid-access: the in-flight access completes and acks; masking applies only to the next arbitration.
- Requester dropping req before ack: protocol violation; the access still completes.
- Reset (async, immediate):
  - state=IDLE, ptr=3 (core 0 has first priority).
  - grant, ack, mem_en, mem_we, mem_addr, mem_wdata = 0.
  - busy=0.
- all_done is registered: (end_op & active_mask)==active_mask && next state IDLE.

Test Plan:
- Reset: rst=1 at arbitrary time, no clock edge → all registered outputs 0 immediately. After release with req=0, mem_en stays 0 for 20 cycles.
- Single read: core_sel=1, req[0]=1, addr 0x010, RAM model holds 0xA5 → mem_en=1/mem_addr=0x010 at T+1, ack=0001 at T+2, rd_data=0xA5.
- Contention: core_sel=4, req=1111, each core drops req after its ack → ack order 0,1,2,3 at T+2, T+4, T+6, T+8; grant always one-hot.
- Masking: core_sel=2, req=1111 → only cores 0 and 1 served, alternating. Then end_op=0001 → only core 1 served. Core_sel=0 behaves as 1.
- Write: core_sel=3, req[2]=1, we[2]=1, addr 0xFFF, wdata 0x5C → mem_we=1/mem_addr=0xFFF/mem_wdata=0x5C for one cycle, then ack=0100.
- Mid-op reset and done: assert rst during ISSUE → mem_en drops at once; after release core 0 wins first. Core_sel=2, end_op=0011, no req → all_done=1. Deasserting end_op[1] → all_done=0 next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port synchronous data RAM
// among up to four multiplier cores. Each access runs IDLE -> ISSUE -> RESP:
// the request is seen in IDLE (cycle T), strobed to the RAM in ISSUE (T+1) and
// acknowledged in RESP (T+2) with the registered RAM's read data.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   core_sel[2:0]        number of active cores (0 -> 1, 5..7 -> 4)
//   end_op[3:0]          per-core finished flags, masks the core from arbitration
//   req/we[3:0]          per-core request (held until ack) and write enable
//   addr_bus, wdata_bus  packed per-core address / write data, core i at slice i
//   grant[3:0]           one-hot owner of the memory (registered)
//   ack[3:0]             one-hot single-cycle completion pulse (registered)
//   rd_data              RAM read data, meaningful only while ack is high
//   mem_en/mem_we/mem_addr/mem_wdata  RAM strobes and payload (registered)
//   mem_rdata            RAM output, one-cycle read latency
//   busy                 FSM not idle (registered)
//   all_done             every active core finished and FSM idle (registered)
module mem_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            core_sel,
  input  logic [3:0]            end_op,
  input  logic [3:0]            req,
  input  logic [3:0]            we,
  input  logic [4*ADDR_W-1:0]   addr_bus,
  input  logic [4*DATA_W-1:0]   wdata_bus,
  output logic [3:0]            grant,
  output logic [3:0]            ack,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic                  all_done
);

  localparam int unsigned N_CORES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        ptr;          // last core served; search starts at ptr+1
  logic [1:0]        win_idx;      // core owning the in-flight access

  logic [3:0]        active_mask_c;
  logic [3:0]        cand_c;
  logic              found_c;
  logic [1:0]        pick_c;
  logic [ADDR_W-1:0] pick_addr_c;
  logic [DATA_W-1:0] pick_wdata_c;
  logic              go_idle_c;
  logic              done_c;

  // Clamp core_sel into 1..4 and expand to a low-order core mask.
  always_comb begin
    active_mask_c = 4'b0001;
    case (core_sel)
      3'd2:    active_mask_c = 4'b0011;
      3'd3:    active_mask_c = 4'b0111;
      3'd4,
      3'd5,
      3'd6,
      3'd7:    active_mask_c = 4'b1111;
      default: active_mask_c = 4'b0001;
    endcase
  end

  // Eligible requesters; in RESP the core being acked still holds req, so drop it.
  always_comb begin
    cand_c = req & active_mask_c & ~end_op;
    if (state == RESP) begin
      cand_c = cand_c & ~(4'b0001 << win_idx);
    end
  end

  // Round-robin search from ptr+1 upward; the fourth step wraps back onto ptr.
  always_comb begin
    found_c = 1'b0;
    pick_c  = ptr;
    for (int k = 1; k <= int'(N_CORES); k++) begin
      if (!found_c && cand_c[2'(ptr + 2'(k))]) begin
        found_c = 1'b1;
        pick_c  = 2'(ptr + 2'(k));
      end
    end
  end

  // Select the winning core's address and write data from the packed buses.
  always_comb begin
    pick_addr_c  = '0;
    pick_wdata_c = '0;
    for (int i = 0; i < int'(N_CORES); i++) begin
      if (pick_c == 2'(i)) begin
        pick_addr_c  = addr_bus[i*ADDR_W +: ADDR_W];
        pick_wdata_c = wdata_bus[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state is IDLE unless an access is in flight or a new winner is found.
  assign go_idle_c = (state != ISSUE) && !found_c;
  assign done_c    = ((end_op & active_mask_c) == active_mask_c) && go_idle_c;

  // Registered RAM returns data in the RESP cycle, aligned with ack.
  assign rd_data = mem_rdata;

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd3;
      win_idx   <= 2'd0;
      grant     <= '0;
      ack       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      all_done  <= 1'b0;
    end else begin
      ack      <= '0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      busy     <= !go_idle_c;
      all_done <= done_c;
      case (state)
        IDLE, RESP: begin
          if (found_c) begin
            state     <= ISSUE;
            win_idx   <= pick_c;
            grant     <= 4'b0001 << pick_c;
            mem_en    <= 1'b1;
            mem_we    <= we[pick_c];
            mem_addr  <= pick_addr_c;
            mem_wdata <= pick_wdata_c;
          end else begin
            state <= IDLE;
            grant <= '0;
          end
        end
        ISSUE: begin
          // Access completes regardless of req/end_op changes since issue.
          state <= RESP;
          ack   <= 4'b0001 << win_idx;
          ptr   <= win_idx;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;

  logic                clk;
  logic                rst;
  logic [2:0]          core_sel;
  logic [3:0]          end_op;
  logic [3:0]          req;
  logic [3:0]          we;
  logic [4*ADDR_W-1:0] addr_bus;
  logic [4*DATA_W-1:0] wdata_bus;
  logic [3:0]          grant;
  logic [3:0]          ack;
  logic [DATA_W-1:0]   rd_data;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;
  logic                all_done;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .core_sel(core_sel), .end_op(end_op),
    .req(req), .we(we), .addr_bus(addr_bus), .wdata_bus(wdata_bus),
    .grant(grant), .ack(ack), .rd_data(rd_data), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .all_done(all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Initial RAM contents; 0x010 holds 0xA5 for the single-read case.
  function automatic logic [7:0] ram_init(input logic [11:0] a);
    if (a == 12'h010) return 8'hA5;
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
  endfunction

  // Active-core mask from core_sel: 0 counts as 1, above 4 counts as 4.
  function automatic logic [3:0] mask_of(input logic [2:0] s);
    int n;
    n = (s == 3'd0) ? 1 : ((s > 3'd4) ? 4 : int'(s));
    return 4'((1 << n) - 1);
  endfunction

  // Registered single-port RAM model.
  logic [7:0] ram [4096];
  initial for (int a = 0; a < 4096; a++) ram[a] = ram_init(12'(a));
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Scoreboard state.
  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t       exp_q [4][$];
  logic [7:0] shadow [4096];

  logic       mon_en      = 1'b0;
  logic [3:0] prev_req    = '0;
  logic [3:0] prev_end    = '0;
  logic [3:0] prev_ack    = '0;
  logic [2:0] prev_sel    = 3'd1;
  logic       prev_mem_en = 1'b0;
  logic [3:0] ack_s       = '0;
  logic [1:0] last        = 2'd3;
  logic [1:0] pend        = 2'd0;
  logic       pend_v      = 1'b0;

  // Monitor: predicts issue/ack from last cycle's inputs and pops the scoreboard.
  always @(negedge clk) begin : monitor
    logic [3:0] cand;
    logic [3:0] exp_ack;
    logic       exp_issue;
    int         win;
    exp_t       e;
    if (rst) begin
      last   = 2'd3;
      pend_v = 1'b0;
    end else if (mon_en) begin
      cand      = prev_req & mask_of(prev_sel) & ~prev_end & ~prev_ack;
      exp_issue = !prev_mem_en && (cand != 4'd0);
      check("grant_onehot0", 32'($onehot0(grant)), 1);
      check("mem_en", mem_en, exp_issue);
      exp_ack = (pend_v && prev_mem_en) ? (4'b0001 << pend) : 4'd0;
      check("ack", ack, exp_ack);
      if (exp_ack != 4'd0 && ack == exp_ack) begin
        if (exp_q[pend].size() > 0) begin
          e = exp_q[pend].pop_front();
          if (!e.w) check("rd_data", rd_data, e.d);
        end
        pend_v = 1'b0;
      end
      if (mem_en && exp_issue) begin
        win = 0;
        for (int k = 4; k >= 1; k--) begin
          if (cand[(int'(last) + k) % 4]) win = (int'(last) + k) % 4;
        end
        check("rr_grant", grant, 4'b0001 << win);
        check("req_pending", 32'(exp_q[win].size() != 0), 1);
        if (exp_q[win].size() != 0) begin
          e = exp_q[win][0];
          check("mem_we", mem_we, e.w);
          check("mem_addr", mem_addr, e.a);
          if (e.w) check("mem_wdata", mem_wdata, e.d);
        end
        pend   = 2'(win);
        pend_v = 1'b1;
        last   = 2'(win);
      end
    end
    prev_req    = req;
    prev_end    = end_op;
    prev_sel    = core_sel;
    prev_ack    = ack;
    prev_mem_en = mem_en;
    ack_s       = ack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; we = '0; end_op = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic issue(input int i);
    exp_t e;
    logic [7:0] wd;
    e.w = 1'($urandom_range(0, 1));
    e.a = {2'(i), 10'($urandom)};
    wd  = 8'($urandom);
    if (e.w) begin
      e.d = wd;
      shadow[e.a] = wd;
    end else begin
      e.d = shadow[e.a];
    end
    addr_bus[i*ADDR_W +: ADDR_W]  = e.a;
    wdata_bus[i*DATA_W +: DATA_W] = wd;
    we[i]  = e.w;
    req[i] = 1'b1;
    exp_q[i].push_back(e);
  endtask

  function automatic logic [3:0] mask_ack(input int c);
    case (c)
      2, 6, 10:          return 4'b0001;
      4, 8, 12, 15, 18:  return 4'b0010;
      default:           return 4'b0000;
    endcase
  endfunction

  initial begin
    int en_cnt;
    int left [4];
    int gap [4];
    logic [3:0] act;
    logic done;
    int pending;

    rst = 1'b0; core_sel = 3'd4; end_op = '0; req = '0; we = '0;
    addr_bus = '0; wdata_bus = '0;
    for (int a = 0; a < 4096; a++) shadow[a] = ram_init(12'(a));

    // Asynchronous reset with no clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_grant", grant, 0);     check("rst_ack", ack, 0);
    check("rst_mem_en", mem_en, 0);   check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0); check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1; rst = 1'b0;
    en_cnt = 0;
    repeat (20) begin
      step();
      @(negedge clk);
      en_cnt += int'(mem_en);
    end
    check("idle_mem_en_count", en_cnt, 0);
    check("idle_busy", busy, 0);

    // Single read from core 0.
    do_reset();
    core_sel = 3'd1; req = 4'b0001; addr_bus[0 +: ADDR_W] = 12'h010;
    step(); @(negedge clk);
    check("rd_mem_en", mem_en, 1);    check("rd_mem_addr", mem_addr, 12'h010);
    check("rd_mem_we", mem_we, 0);    check("rd_grant", grant, 4'b0001);
    check("rd_busy", busy, 1);        check("rd_ack_early", ack, 0);
    step(); @(negedge clk);
    check("rd_ack", ack, 4'b0001);    check("rd_data", rd_data, 8'hA5);
    check("rd_mem_en_off", mem_en, 0);
    step(); req = '0; @(negedge clk);
    check("rd_ack_clear", ack, 0);    check("rd_busy_clear", busy, 0);

    // Full contention, each core drops req after its ack.
    do_reset();
    core_sel = 3'd4; req = 4'b1111;
    for (int c = 1; c <= 9; c++) begin
      step();
      req = req & ~ack_s;
      @(negedge clk);
      check("cont_ack", ack, (c % 2 == 0 && c <= 8) ? (4'b0001 << ((c - 2) / 2)) : 4'd0);
      check("cont_grant", grant, (c <= 8) ? (4'b0001 << ((c - 1) / 2)) : 4'd0);
    end
    check("cont_busy_end", busy, 0);
    req = '0;

    // Masking: two active cores alternate, then core 0 finishes mid-access.
    do_reset();
    core_sel = 3'd2; req = 4'b1111;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 9) end_op = 4'b0001;
      @(negedge clk);
      check("mask_ack", ack, mask_ack(c));
      check("mask_grant_hi", grant & 4'b1100, 0);
    end
    req = '0;

    // core_sel = 0 behaves as one active core.
    do_reset();
    core_sel = 3'd0; req = 4'b0011;
    for (int c = 1; c <= 8; c++) begin
      step();
      @(negedge clk);
      check("sel0_ack", ack, (c == 2 || c == 5 || c == 8) ? 4'b0001 : 4'b0000);
      check("sel0_grant1", grant[1], 0);
    end
    req = '0;

    // Write from core 2 to the top address.
    do_reset();
    core_sel = 3'd3; req = 4'b0100; we = 4'b0100;
    addr_bus[2*ADDR_W +: ADDR_W] = 12'hFFF; wdata_bus[2*DATA_W +: DATA_W] = 8'h5C;
    step(); @(negedge clk);
    check("wr_mem_en", mem_en, 1);    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 12'hFFF); check("wr_mem_wdata", mem_wdata, 8'h5C);
    check("wr_grant", grant, 4'b0100);
    step(); @(negedge clk);
    check("wr_ack", ack, 4'b0100);    check("wr_mem_we_off", mem_we, 0);
    check("wr_mem_en_off", mem_en, 0);
    step(); req = '0; we = '0;
    check("wr_ram", ram[12'hFFF], 8'h5C);
    shadow[12'hFFF] = 8'h5C;

    // Reset during ISSUE of core 1 (core 0 already served).
    do_reset();
    core_sel = 3'd4; req = 4'b0011;
    step(); step(); step(); @(negedge clk);
    check("mid_pre_mem_en", mem_en, 1); check("mid_pre_grant", grant, 4'b0010);
    #2 rst = 1'b1;
    #1;
    check("mid_mem_en", mem_en, 0);   check("mid_grant", grant, 0);
    check("mid_busy", busy, 0);       check("mid_ack", ack, 0);
    @(posedge clk); #1; rst = 1'b0;
    step(); @(negedge clk);
    check("post_rst_grant", grant, 4'b0001); check("post_rst_mem_en", mem_en, 1);
    step(); step(); req = '0;
    repeat (3) step();

    // all_done with two active cores both finished.
    core_sel = 3'd2; end_op = 4'b0011;
    step(); step(); @(negedge clk);
    check("all_done_set", all_done, 1);
    step(); end_op = 4'b0001; @(negedge clk);
    check("all_done_hold", all_done, 1);
    step(); @(negedge clk);
    check("all_done_clear", all_done, 0);

    // Randomised phases checked by the scoreboard monitor.
    do_reset();
    mon_en = 1'b1;
    for (int p = 0; p < 8; p++) begin
      core_sel = 3'($urandom_range(0, 7));
      end_op   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      act      = mask_of(core_sel) & ~end_op;
      for (int i = 0; i < 4; i++) begin
        left[i] = act[i] ? 6 : 0;
        gap[i]  = $urandom_range(0, 2);
        if (!act[i] && $urandom_range(0, 1) == 1) begin
          addr_bus[i*ADDR_W +: ADDR_W] = 12'($urandom);
          we[i]  = 1'b0;
          req[i] = 1'b1;
        end
      end
      done = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
        step();
        done = (cyc >= 20);
        for (int i = 0; i < 4; i++) begin
          if (act[i]) begin
            if (req[i]) begin
              if (ack_s[i]) begin
                req[i]  = 1'b0;
                we[i]   = 1'b0;
                left[i] = left[i] - 1;
                gap[i]  = $urandom_range(0, 3);
              end
            end else if (left[i] > 0) begin
              if (gap[i] == 0) issue(i);
              else gap[i] = gap[i] - 1;
            end
            if (req[i] || left[i] > 0) done = 1'b0;
          end
        end
      end
      check("phase_complete", done, 1);
      req = '0; we = '0;
      repeat (3) step();
    end
    @(negedge clk);
    mon_en = 1'b0;
    pending = 0;
    for (int i = 0; i < 4; i++) pending += exp_q[i].size();
    check("scoreboard_drained", pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
